// File: rtl/uart_pkg.sv
// Shared definitions for the UART link (transmitter `uart` and receiver
// `uart_rx`).
//   - uart_state_e      : receiver FSM state encoding (3-bit)
//   - UART_DATA_BITS    : payload bits per frame
//   - UART_CLKS_PER_BIT : default clock cycles per bit period
package uart_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Input conditioning for the UART receiver.
// Two-flop synchroniser on the asynchronous serial line, followed by one
// history flop so a falling edge of the synchronised line can be detected.
// All flops reset to 1, the idle level of the line, so leaving reset never
// looks like a start edge.
// Ports:
//   clk   in  system clock
//   reset in  synchronous active-high reset
//   rx    in  raw serial line (asynchronous)
//   rx_s  out synchronised line
//   fall  out high for one cycle when rx_s goes 1 -> 0
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic hist_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      hist_q <= 1'b1;
    end else begin
      meta_q <= rx;
      sync_q <= meta_q;
      hist_q <= sync_q;
    end
  end

  assign rx_s = sync_q;
  assign fall = hist_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: deserialises the serial line into bytes, LSB first, with
// mid-bit sampling at a fixed CLKS_PER_BIT ratio (must be >= 4).
// Optional build macro UART_RX_PARITY_EN: frames become 8E1 (even parity
// bit after the data bits); otherwise 8N1 and parity_err is tied 0.
// Ports:
//   clk        in  system clock, rising edge
//   reset      in  synchronous active-high reset, aborts any frame silently
//   rx         in  serial line, idle high, asynchronous
//   data       out last good byte, held until the next good frame
//   rx_valid   out one-cycle pulse, data updated this cycle
//   rx_busy    out high from start detect until back in IDLE
//   frame_err  out one-cycle pulse, stop bit sampled low
//   parity_err out one-cycle pulse, parity mismatch (0 without the macro)
// The FSM state is held in state_q (uart_state_e) for observation.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  logic rx_s;
  logic fall;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .rx_s  (rx_s),
    .fall  (fall)
  );

  uart_state_e          state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 rx_valid_q;
  logic                 rx_busy_q;
  logic                 frame_err_q;
  logic                 parity_bad;

`ifdef UART_RX_PARITY_EN
  logic parity_q;
  logic parity_err_q;
  // Even parity: XOR over data bits and parity bit must be zero.
  assign parity_bad = ^{shift_q, parity_q};
  assign parity_err = parity_err_q;
`else
  assign parity_bad = 1'b0;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      rx_valid_q  <= 1'b0;
      rx_busy_q   <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_q     <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          rx_busy_q <= 1'b0;
          // Only an edge starts a frame, so a held-low line cannot retrigger.
          if (fall) begin
            cnt_q     <= '0;
            state_q   <= START;
            rx_busy_q <= 1'b1;
          end
        end
        START: begin
          if (cnt_q == HALF_LAST) begin
            if (!rx_s) begin
              cnt_q     <= '0;
              bit_idx_q <= '0;
              state_q   <= DATA;
            end else begin
              // Line back high at mid-start: glitch, drop it silently.
              state_q   <= IDLE;
              rx_busy_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == BIT_LAST) begin
            shift_q[bit_idx_q] <= rx_s;
            cnt_q              <= '0;
            if (bit_idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_q == BIT_LAST) begin
            parity_q <= rx_s;
            cnt_q    <= '0;
            state_q  <= STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt_q == BIT_LAST) begin
            if (rx_s && !parity_bad) begin
              data_q     <= shift_q;
              rx_valid_q <= 1'b1;
            end
            frame_err_q <= ~rx_s;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= parity_bad;
`endif
            cnt_q     <= '0;
            state_q   <= IDLE;
            rx_busy_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          rx_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign data      = data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_busy   = rx_busy_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: directed frames from the test plan followed by a
// run of random frames, each compared against a frame-level model of what
// the receiver should report (good bytes, frame errors, parity errors).
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       parity_err;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .data       (data),
    .rx_valid   (rx_valid),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         n_checks  = 0;
  int         n_errors  = 0;
  int         fe_cnt    = 0;
  int         pe_cnt    = 0;
  int         both_cnt  = 0;
  int         busy_viol = 0;
  int         exp_fe    = 0;
  int         exp_pe    = 0;
  logic [7:0] last_good = 8'h00;
  bit         watch_busy = 1'b0;

  // Monitor samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid) obs_q.push_back(data);
      if (frame_err) fe_cnt++;
      if (parity_err) pe_cnt++;
      if (rx_valid && frame_err) both_cnt++;
      if (watch_busy && !rx_busy) busy_viol++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A frame yields a byte only with a good stop bit and good parity; a low
  // stop bit is a frame error; bad parity is a parity error (8E1 only).
  task automatic model_frame(input logic [7:0] b, input logic stop_ok, input logic par_ok);
    if (stop_ok && (par_ok || !PAR_EN)) begin
      exp_q.push_back(b);
      last_good = b;
    end
    if (!stop_ok) exp_fe++;
    if (PAR_EN && !par_ok) exp_pe++;
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic level, input int n);
    rx = level;
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic flip_par);
    logic par;
    par = (^b) ^ flip_par;
    drive(1'b0, 5);
    watch_busy = 1'b1;
    drive(1'b0, CPB - 5);
    for (int i = 0; i < 8; i++) drive(b[i], CPB);
    if (PAR_EN) drive(par, CPB);
    drive(stop_bit, 4);
    watch_busy = 1'b0;
    drive(stop_bit, CPB - 4);
    model_frame(b, stop_bit, !flip_par);
  endtask

  task automatic check_segment(input string tag);
    check({tag, " count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check({tag, " byte"}, {24'd0, obs_q[i]}, {24'd0, exp_q[i]});
    check({tag, " frame_err count"}, fe_cnt, exp_fe);
    check({tag, " parity_err count"}, pe_cnt, exp_pe);
    check({tag, " valid+ferr overlap"}, both_cnt, 0);
    check({tag, " busy dropout"}, busy_viol, 0);
    check({tag, " data hold"}, {24'd0, data}, {24'd0, last_good});
    check({tag, " busy idle"}, {31'd0, rx_busy}, 32'd0);
    obs_q.delete();
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] b;
    logic       bad_stop;
    logic       flip;
    int         gap;

    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) tick();
    check("reset data", {24'd0, data}, 32'd0);
    check("reset rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset rx_busy", {31'd0, rx_busy}, 32'd0);
    check("reset frame_err", {31'd0, frame_err}, 32'd0);
    check("reset parity_err", {31'd0, parity_err}, 32'd0);
    check("reset state", {29'd0, dut.state_q}, {29'd0, IDLE});
    reset = 1'b0;
    drive(1'b1, 5);

    // Single byte.
    send_frame(8'hA5, 1'b1, 1'b0);
    drive(1'b1, 20);
    check_segment("a5");

    // Back-to-back with only one stop bit between frames.
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h00, 1'b1, 1'b0);
    drive(1'b1, 20);
    check_segment("ff_00");

    // Short low glitch is rejected at mid-start.
    drive(1'b0, 3);
    drive(1'b1, 17);
    check("glitch busy", {31'd0, rx_busy}, 32'd0);
    check("glitch state", {29'd0, dut.state_q}, {29'd0, IDLE});
    send_frame(8'h3C, 1'b1, 1'b0);
    drive(1'b1, 20);
    check_segment("glitch_3c");

    // Bad stop followed by a break: one frame error, no retrigger.
    send_frame(8'h55, 1'b0, 1'b0);
    drive(1'b0, 40);
    check("break busy", {31'd0, rx_busy}, 32'd0);
    check("break state", {29'd0, dut.state_q}, {29'd0, IDLE});
    drive(1'b1, CPB);
    check_segment("break_55");

    // Reset in the middle of data bit 4 aborts the frame silently.
    drive(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive(1'b1, CPB);
    drive(1'b0, CPB / 2);
    reset = 1'b1;
    rx    = 1'b1;
    tick();
    check("abort data", {24'd0, data}, 32'd0);
    check("abort rx_valid", {31'd0, rx_valid}, 32'd0);
    check("abort rx_busy", {31'd0, rx_busy}, 32'd0);
    check("abort frame_err", {31'd0, frame_err}, 32'd0);
    check("abort state", {29'd0, dut.state_q}, {29'd0, IDLE});
    reset     = 1'b0;
    last_good = 8'h00;
    drive(1'b1, 10);
    send_frame(8'h81, 1'b1, 1'b0);
    drive(1'b1, 20);
    check_segment("after_reset_81");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    drive(1'b1, 20);
    check_segment("par_good_07");
    send_frame(8'h07, 1'b1, 1'b1);
    drive(1'b1, 20);
    check_segment("par_bad_07");
`endif

    // Random frames, occasional bad stop bits and bad parity, random gaps.
    for (int n = 0; n < 24; n++) begin
      b        = 8'($urandom_range(0, 255));
      bad_stop = ($urandom_range(0, 7) == 0);
      flip     = PAR_EN && ($urandom_range(0, 5) == 0);
      send_frame(b, !bad_stop, flip);
      gap = bad_stop ? $urandom_range(4, 20) : $urandom_range(0, 20);
      drive(1'b1, gap);
    end
    drive(1'b1, 20);
    check_segment("random");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
